battleship_turn_ctrl: RTL and testbench
=======================================

BATTLESHIP_TURN_CTRL -- requirements
Module: battleship_turn_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  TURN_TIMEOUT  50_000_000  cycles allowed per turn before automatic pass.
  MAX_SHIPS     5           largest accepted ship count.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk                     in   1  single clock; all state updates on rising edge.
  rst                     in   1  asynchronous, active-high reset.
  start_btn               in   1  synchronous level; rising edge detected internally.
  ships_cfg               in   3  requested ship count.
  place_done              in   1  one-cycle pulse from the placement block per ship placed.
  player_shot_valid       in   1  one-cycle pulse: player fired.
  player_hit              in   1  qualifies player_shot_valid: shot hit.
  pc_shot_valid           in   1  one-cycle pulse: PC fired.
  pc_hit                  in   1  qualifies pc_shot_valid: shot hit.
  colocation_ships_State  out  1  high while in PLACE; enables the placement block.
  player_turn             out  1  high in PLAYER.
  pc_turn                 out  1  high in PC.
  state                   out  3  encoded FSM state.
  player_hits             out  4  hits scored by player.
  pc_hits                 out  4  hits scored by PC.
  ships_placed            out  3  place_done pulses counted in PLACE.
  win                     out  1  high in WIN.
  lose                    out  1  high in LOSE.
  timeout_pulse           out  1  one-cycle pulse on turn timeout.

Function
REQ-003 State encoding SHALL be: IDLE=0, PLACE=1, PLAYER=2, PC=3, WIN=4, LOSE=5; codes 6-7 SHALL return to IDLE on the next edge.
REQ-004 The start edge SHALL be defined as start_btn=1 this cycle and 0 in the previous cycle, using a registered copy of start_btn.
REQ-005 In IDLE, on a start edge with ships_cfg in 1..MAX_SHIPS, the block SHALL:
  - latch n_ships = ships_cfg;
  - latch req_hits = n*(n+1)/2 (max 15);
  - clear ships_placed, player_hits, pc_hits and the turn timer;
  - enter PLACE next cycle.
REQ-006 A start edge in IDLE with ships_cfg equal to 0 or greater than MAX_SHIPS SHALL be ignored.
REQ-007 colocation_ships_State, player_turn, pc_turn, win and lose SHALL be registered decodes of the state, valid in the same cycle the state is entered.
REQ-008 In PLACE:
  - each place_done pulse SHALL increment ships_placed;
  - on the edge where the count reaches n_ships, the FSM SHALL enter PLAYER;
  - the turn timer SHALL NOT run.
REQ-009 place_done outside PLACE SHALL be ignored.
REQ-010 In PLAYER, on player_shot_valid:
  - player_hits SHALL increment if player_hit=1;
  - if the new player_hits equals req_hits, next state SHALL be WIN, else PC.
REQ-011 In PC, on pc_shot_valid:
  - pc_hits SHALL increment if pc_hit=1;
  - if the new pc_hits equals req_hits, next state SHALL be LOSE, else PLAYER.
REQ-012 Shot pulses from the side not holding the turn, and all shot pulses outside PLAYER and PC, SHALL be ignored.
REQ-013 Turn timer (32-bit):
  - SHALL clear on every entry to PLAYER or PC;
  - SHALL increment each cycle while in that state;
  - on reaching TURN_TIMEOUT-1 with no shot that cycle: assert timeout_pulse for one cycle, pass the turn (PLAYER to PC, PC to PLAYER), leave hit counters unchanged.
REQ-014 If a shot and the timeout occur in the same cycle, the shot SHALL take priority and timeout_pulse SHALL stay low.
REQ-015 Hit counters SHALL saturate at 15 and never wrap.
REQ-016 WIN and LOSE SHALL hold until a start edge, which SHALL return the FSM to IDLE; counters SHALL hold their values until the next game starts.
REQ-017 A start edge in PLACE, PLAYER or PC SHALL abort the game to IDLE, with counters unchanged.

Reset
REQ-018 While rst=1, asynchronously:
  - state=IDLE;
  - all outputs 0, counters 0, timer 0;
  - n_ships=0, req_hits=0;
  - the registered start_btn copy = 0.
REQ-019 Deassertion of rst mid-game SHALL restart from IDLE; no start edge SHALL be inferred from start_btn already high at release.

Verification
REQ-020 Reset: with start_btn=1 held through release -> state stays IDLE, all outputs 0.
REQ-021 Setup: ships_cfg=2, start edge -> PLACE; two place_done pulses -> ships_placed=2, PLAYER; req_hits=3.
REQ-022 Game to win: ships_cfg=1; player hit -> WIN (win=1, player_hits=1); PC pulse while in WIN -> ignored.
REQ-023 Alternation: ships_cfg=2; alternate player miss / PC hit three times -> LOSE, pc_hits=3, player_hits=0.
REQ-024 Timeout: TURN_TIMEOUT=8; no shots in PLAYER -> timeout_pulse on the 8th cycle of PLAYER, PC next. Repeat with a shot on that same cycle -> no timeout_pulse.
REQ-025 Illegal config and abort: ships_cfg=0 or 6, start edge -> remain IDLE. A start edge during PC -> IDLE.

Source files
------------

// File: rtl/battleship_turn_ctrl_if.sv
// Signal bundle between the battleship turn controller and the game front end.
// The controller takes the slave side; the driving environment takes the master side.
interface battleship_turn_ctrl_if;
  logic       start_btn;
  logic [2:0] ships_cfg;
  logic       place_done;
  logic       player_shot_valid;
  logic       player_hit;
  logic       pc_shot_valid;
  logic       pc_hit;
  logic       colocation_ships_State;
  logic       player_turn;
  logic       pc_turn;
  logic [2:0] state;
  logic [3:0] player_hits;
  logic [3:0] pc_hits;
  logic [2:0] ships_placed;
  logic       win;
  logic       lose;
  logic       timeout_pulse;

  modport master (
    output start_btn, ships_cfg, place_done, player_shot_valid, player_hit,
           pc_shot_valid, pc_hit,
    input  colocation_ships_State, player_turn, pc_turn, state, player_hits,
           pc_hits, ships_placed, win, lose, timeout_pulse
  );

  modport slave (
    input  start_btn, ships_cfg, place_done, player_shot_valid, player_hit,
           pc_shot_valid, pc_hit,
    output colocation_ships_State, player_turn, pc_turn, state, player_hits,
           pc_hits, ships_placed, win, lose, timeout_pulse
  );
endinterface

// File: rtl/battleship_turn_ctrl.sv
// Game sequencer for battleship: ship placement, alternating turns with a per-turn
// timeout, hit counting and win/lose detection.
module battleship_turn_ctrl #(
  parameter int TURN_TIMEOUT = 50_000_000,
  parameter int MAX_SHIPS    = 5
) (
  input logic                  clk,
  input logic                  rst,
  battleship_turn_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLACE  = 3'd1,
    PLAYER = 3'd2,
    PC     = 3'd3,
    WIN    = 3'd4,
    LOSE   = 3'd5
  } state_t;

  localparam logic [31:0] TIMER_LAST = 32'(TURN_TIMEOUT - 1);

  state_t      st, st_nxt;
  logic        start_q, armed, start_edge, cfg_ok, game_start, timeout_now;
  logic [2:0]  n_ships, placed, placed_nxt;
  logic [3:0]  req_hits, p_hits, c_hits, p_hits_nxt, c_hits_nxt;
  logic [31:0] timer;
  logic        place_f, player_f, pc_f, win_f, lose_f;

  function automatic logic [3:0] tri_num(input logic [2:0] n);
    case (n)
      3'd1:    tri_num = 4'd1;
      3'd2:    tri_num = 4'd3;
      3'd3:    tri_num = 4'd6;
      3'd4:    tri_num = 4'd10;
      default: tri_num = 4'd15;
    endcase
  endfunction

  // armed blocks a phantom edge when start_btn is already high as reset releases
  assign start_edge = armed && bus.start_btn && !start_q;
  assign cfg_ok     = (bus.ships_cfg != 3'd0) && (int'(bus.ships_cfg) <= MAX_SHIPS);
  assign game_start = start_edge && cfg_ok;

  // Combinational so the pulse lands in the expiring cycle and a same-cycle shot can veto it
  assign timeout_now = !start_edge && (timer == TIMER_LAST) &&
                       (((st == PLAYER) && !bus.player_shot_valid) ||
                        ((st == PC) && !bus.pc_shot_valid));

  always_comb begin
    st_nxt     = st;
    placed_nxt = placed;
    p_hits_nxt = p_hits;
    c_hits_nxt = c_hits;
    case (st)
      IDLE: begin
        if (game_start) begin
          st_nxt     = PLACE;
          placed_nxt = 3'd0;
          p_hits_nxt = 4'd0;
          c_hits_nxt = 4'd0;
        end
      end
      PLACE: begin
        if (start_edge) begin
          st_nxt = IDLE;
        end else if (bus.place_done) begin
          placed_nxt = placed + 3'd1;
          if (placed_nxt == n_ships) st_nxt = PLAYER;
        end
      end
      PLAYER: begin
        if (start_edge) begin
          st_nxt = IDLE;
        end else if (bus.player_shot_valid) begin
          if (bus.player_hit && (p_hits != 4'd15)) p_hits_nxt = p_hits + 4'd1;
          st_nxt = (p_hits_nxt == req_hits) ? WIN : PC;
        end else if (timeout_now) begin
          st_nxt = PC;
        end
      end
      PC: begin
        if (start_edge) begin
          st_nxt = IDLE;
        end else if (bus.pc_shot_valid) begin
          if (bus.pc_hit && (c_hits != 4'd15)) c_hits_nxt = c_hits + 4'd1;
          st_nxt = (c_hits_nxt == req_hits) ? LOSE : PLAYER;
        end else if (timeout_now) begin
          st_nxt = PLAYER;
        end
      end
      WIN, LOSE: begin
        if (start_edge) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      start_q  <= 1'b0;
      armed    <= 1'b0;
      n_ships  <= 3'd0;
      req_hits <= 4'd0;
      placed   <= 3'd0;
      p_hits   <= 4'd0;
      c_hits   <= 4'd0;
      timer    <= 32'd0;
      place_f  <= 1'b0;
      player_f <= 1'b0;
      pc_f     <= 1'b0;
      win_f    <= 1'b0;
      lose_f   <= 1'b0;
    end else begin
      start_q <= bus.start_btn;
      armed   <= 1'b1;
      st      <= st_nxt;
      placed  <= placed_nxt;
      p_hits  <= p_hits_nxt;
      c_hits  <= c_hits_nxt;
      if ((st == IDLE) && game_start) begin
        n_ships  <= bus.ships_cfg;
        req_hits <= tri_num(bus.ships_cfg);
      end
      // Any state change restarts the turn timer; it only advances while a turn is held
      if (st_nxt != st) begin
        timer <= 32'd0;
      end else if ((st == PLAYER) || (st == PC)) begin
        timer <= timer + 32'd1;
      end
      place_f  <= (st_nxt == PLACE);
      player_f <= (st_nxt == PLAYER);
      pc_f     <= (st_nxt == PC);
      win_f    <= (st_nxt == WIN);
      lose_f   <= (st_nxt == LOSE);
    end
  end

  assign bus.state                  = st;
  assign bus.colocation_ships_State = place_f;
  assign bus.player_turn            = player_f;
  assign bus.pc_turn                = pc_f;
  assign bus.win                    = win_f;
  assign bus.lose                   = lose_f;
  assign bus.player_hits            = p_hits;
  assign bus.pc_hits                = c_hits;
  assign bus.ships_placed           = placed;
  assign bus.timeout_pulse          = timeout_now;

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Self-checking bench for battleship_turn_ctrl: directed scenarios plus a long
// randomized run compared against a rule-level game model.
module tb_battleship_turn_ctrl;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  battleship_turn_ctrl_if bus();

  battleship_turn_ctrl #(.TURN_TIMEOUT(TO), .MAX_SHIPS(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_state, m_n, m_req, m_placed, m_ph, m_ch, m_timer;
  bit   m_prev, m_armed, m_tp;
  logic tp_seen;
  logic [18:0] dut_snap;

  assign dut_snap = {bus.state, bus.player_hits, bus.pc_hits, bus.ships_placed,
                     bus.colocation_ships_State, bus.player_turn, bus.pc_turn,
                     bus.win, bus.lose};

  function automatic logic [18:0] exp_snap();
    return {3'(m_state), 4'(m_ph), 4'(m_ch), 3'(m_placed),
            m_state == 1, m_state == 2, m_state == 3, m_state == 4, m_state == 5};
  endfunction

  // Game rules as seen by a player: what one clock edge does given this cycle's inputs
  task automatic model_reset();
    m_state = 0; m_n = 0; m_req = 0; m_placed = 0; m_ph = 0; m_ch = 0;
    m_timer = 0; m_prev = 0; m_armed = 0; m_tp = 0;
  endtask

  task automatic model_tick();
    bit press;
    int cfg;
    press = m_armed && bus.start_btn && !m_prev;
    cfg   = int'(bus.ships_cfg);
    m_tp  = 0;
    if (m_state == 0) begin
      if (press && cfg >= 1 && cfg <= 5) begin
        m_n = cfg;
        m_req = (cfg * (cfg + 1)) / 2;
        if (m_req > 15) m_req = 15;
        m_placed = 0; m_ph = 0; m_ch = 0;
        m_state = 1;
      end
    end else if (press) begin
      m_state = 0;
    end else if (m_state == 1) begin
      if (bus.place_done) begin
        m_placed = m_placed + 1;
        if (m_placed == m_n) begin m_state = 2; m_timer = 0; end
      end
    end else if (m_state == 2 || m_state == 3) begin
      bit shot, hit;
      shot = (m_state == 2) ? bus.player_shot_valid : bus.pc_shot_valid;
      hit  = (m_state == 2) ? bus.player_hit : bus.pc_hit;
      if (shot) begin
        if (m_state == 2) begin
          if (hit) m_ph = (m_ph < 15) ? m_ph + 1 : 15;
          m_state = (m_ph == m_req) ? 4 : 3;
        end else begin
          if (hit) m_ch = (m_ch < 15) ? m_ch + 1 : 15;
          m_state = (m_ch == m_req) ? 5 : 2;
        end
        m_timer = 0;
      end else if (m_timer == TO - 1) begin
        m_tp = 1;
        m_state = (m_state == 2) ? 3 : 2;
        m_timer = 0;
      end else begin
        m_timer = m_timer + 1;
      end
    end
    m_prev  = bus.start_btn;
    m_armed = 1;
  endtask

  // One clock: sample the combinational pulse, advance the model, cross the edge, drop pulses
  task automatic tick();
    #1;
    tp_seen = bus.timeout_pulse;
    model_tick();
    @(posedge clk);
    #1;
    bus.place_done = 1'b0;
    bus.player_shot_valid = 1'b0;
    bus.pc_shot_valid = 1'b0;
  endtask

  task automatic begin_game(input logic [2:0] cfg);
    if (m_state != 0) begin
      bus.start_btn = 1'b0; tick();
      bus.start_btn = 1'b1; tick();
    end
    bus.start_btn = 1'b0; tick();
    bus.ships_cfg = cfg;
    bus.start_btn = 1'b1; tick();
    bus.start_btn = 1'b0;
    for (int i = 0; i < int'(cfg); i++) begin
      bus.place_done = 1'b1; tick();
    end
  endtask

  task automatic test_reset();
    bus.start_btn = 1'b1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dut_snap !== 19'd0) begin
      n_errors++; $display("[TB] FAIL reset_outputs: got %h expected %h", dut_snap, 19'd0);
    end
    n_checks++;
    if (bus.timeout_pulse !== 1'b0) begin
      n_errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", bus.timeout_pulse);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dut_snap !== 19'd0) begin
        n_errors++; $display("[TB] FAIL reset_release_idle: cycle %0d got %h expected %h", i, dut_snap, 19'd0);
      end
    end
    bus.start_btn = 1'b0;
    tick();
  endtask

  task automatic test_setup();
    bus.ships_cfg = 3'd2;
    bus.start_btn = 1'b1; tick();
    bus.start_btn = 1'b0;
    n_checks++;
    if (bus.state !== 3'd1 || bus.colocation_ships_State !== 1'b1) begin
      n_errors++; $display("[TB] FAIL setup_place: got state %0d coloc %b expected 1 1", bus.state, bus.colocation_ships_State);
    end
    bus.place_done = 1'b1; tick();
    n_checks++;
    if (bus.ships_placed !== 3'd1 || bus.state !== 3'd1) begin
      n_errors++; $display("[TB] FAIL setup_first_ship: got placed %0d state %0d expected 1 1", bus.ships_placed, bus.state);
    end
    tick();
    n_checks++;
    if (bus.ships_placed !== 3'd1) begin
      n_errors++; $display("[TB] FAIL setup_no_pulse: got placed %0d expected 1", bus.ships_placed);
    end
    bus.place_done = 1'b1; tick();
    n_checks++;
    if (bus.ships_placed !== 3'd2 || bus.state !== 3'd2 || bus.player_turn !== 1'b1 || bus.colocation_ships_State !== 1'b0) begin
      n_errors++; $display("[TB] FAIL setup_player: got placed %0d state %0d pturn %b coloc %b expected 2 2 1 0",
                           bus.ships_placed, bus.state, bus.player_turn, bus.colocation_ships_State);
    end
    bus.place_done = 1'b1; tick();
    n_checks++;
    if (bus.ships_placed !== 3'd2) begin
      n_errors++; $display("[TB] FAIL setup_place_ignored: got placed %0d expected 2", bus.ships_placed);
    end
  endtask

  task automatic test_win();
    begin_game(3'd1);
    bus.player_shot_valid = 1'b1; bus.player_hit = 1'b1; tick();
    n_checks++;
    if (bus.state !== 3'd4 || bus.win !== 1'b1 || bus.player_hits !== 4'd1) begin
      n_errors++; $display("[TB] FAIL win_reached: got state %0d win %b hits %0d expected 4 1 1", bus.state, bus.win, bus.player_hits);
    end
    bus.pc_shot_valid = 1'b1; bus.pc_hit = 1'b1; tick();
    n_checks++;
    if (bus.state !== 3'd4 || bus.pc_hits !== 4'd0 || bus.lose !== 1'b0) begin
      n_errors++; $display("[TB] FAIL win_pc_ignored: got state %0d pc_hits %0d lose %b expected 4 0 0", bus.state, bus.pc_hits, bus.lose);
    end
  endtask

  task automatic test_alternation();
    begin_game(3'd2);
    for (int i = 1; i <= 3; i++) begin
      bus.player_shot_valid = 1'b1; bus.player_hit = 1'b0; tick();
      n_checks++;
      if (bus.state !== 3'd3 || bus.pc_turn !== 1'b1) begin
        n_errors++; $display("[TB] FAIL alt_to_pc: round %0d got state %0d pc_turn %b expected 3 1", i, bus.state, bus.pc_turn);
      end
      bus.pc_shot_valid = 1'b1; bus.pc_hit = 1'b1; tick();
    end
    n_checks++;
    if (bus.state !== 3'd5 || bus.lose !== 1'b1 || bus.pc_hits !== 4'd3 || bus.player_hits !== 4'd0) begin
      n_errors++; $display("[TB] FAIL alt_lose: got state %0d lose %b pc_hits %0d player_hits %0d expected 5 1 3 0",
                           bus.state, bus.lose, bus.pc_hits, bus.player_hits);
    end
    bus.start_btn = 1'b1; tick();
    bus.start_btn = 1'b0;
    n_checks++;
    if (bus.state !== 3'd0 || bus.pc_hits !== 4'd3) begin
      n_errors++; $display("[TB] FAIL alt_restart_hold: got state %0d pc_hits %0d expected 0 3", bus.state, bus.pc_hits);
    end
  endtask

  task automatic test_timeout();
    bit early;
    begin_game(3'd1);
    early = 0;
    for (int i = 0; i < TO - 1; i++) begin tick(); if (tp_seen !== 1'b0) early = 1; end
    n_checks++;
    if (early || bus.state !== 3'd2) begin
      n_errors++; $display("[TB] FAIL timeout_early: got early %b state %0d expected 0 2", early, bus.state);
    end
    tick();
    n_checks++;
    if (tp_seen !== 1'b1 || bus.state !== 3'd3 || bus.player_hits !== 4'd0) begin
      n_errors++; $display("[TB] FAIL timeout_player: got pulse %b state %0d hits %0d expected 1 3 0", tp_seen, bus.state, bus.player_hits);
    end
    tick();
    n_checks++;
    if (tp_seen !== 1'b0) begin
      n_errors++; $display("[TB] FAIL timeout_one_cycle: got pulse %b expected 0", tp_seen);
    end
    for (int i = 0; i < TO - 2; i++) tick();
    bus.pc_shot_valid = 1'b1; bus.pc_hit = 1'b0; tick();
    n_checks++;
    if (tp_seen !== 1'b0 || bus.state !== 3'd2) begin
      n_errors++; $display("[TB] FAIL timeout_pc_shot_wins: got pulse %b state %0d expected 0 2", tp_seen, bus.state);
    end
    for (int i = 0; i < TO - 1; i++) tick();
    bus.player_shot_valid = 1'b1; bus.player_hit = 1'b0; tick();
    n_checks++;
    if (tp_seen !== 1'b0 || bus.state !== 3'd3) begin
      n_errors++; $display("[TB] FAIL timeout_player_shot_wins: got pulse %b state %0d expected 0 3", tp_seen, bus.state);
    end
  endtask

  task automatic test_illegal_abort();
    logic [2:0] bad [3];
    bad[0] = 3'd0; bad[1] = 3'd6; bad[2] = 3'd7;
    bus.start_btn = 1'b0; tick();
    bus.start_btn = 1'b1; tick();
    n_checks++;
    if (bus.state !== 3'd0 || bus.pc_turn !== 1'b0) begin
      n_errors++; $display("[TB] FAIL abort_from_pc: got state %0d pc_turn %b expected 0 0", bus.state, bus.pc_turn);
    end
    for (int i = 0; i < 3; i++) begin
      bus.start_btn = 1'b0; tick();
      bus.ships_cfg = bad[i];
      bus.start_btn = 1'b1; tick();
      n_checks++;
      if (bus.state !== 3'd0) begin
        n_errors++; $display("[TB] FAIL illegal_cfg_%0d: got state %0d expected 0", bad[i], bus.state);
      end
    end
    begin_game(3'd3);
    bus.player_shot_valid = 1'b1; bus.player_hit = 1'b1; tick();
    bus.start_btn = 1'b1; tick();
    bus.start_btn = 1'b0;
    n_checks++;
    if (bus.state !== 3'd0 || bus.player_hits !== 4'd1 || bus.ships_placed !== 3'd3) begin
      n_errors++; $display("[TB] FAIL abort_hold_counts: got state %0d hits %0d placed %0d expected 0 1 3",
                           bus.state, bus.player_hits, bus.ships_placed);
    end
  endtask

  task automatic test_midgame_reset();
    begin_game(3'd2);
    bus.player_shot_valid = 1'b1; bus.player_hit = 1'b1; tick();
    bus.start_btn = 1'b1;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (dut_snap !== 19'd0) begin
      n_errors++; $display("[TB] FAIL midgame_reset_async: got %h expected %h", dut_snap, 19'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(); tick();
    n_checks++;
    if (dut_snap !== 19'd0) begin
      n_errors++; $display("[TB] FAIL midgame_reset_no_edge: got %h expected %h", dut_snap, 19'd0);
    end
    bus.start_btn = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) bus.start_btn = ~bus.start_btn;
      bus.ships_cfg = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 3));
      bus.place_done        = ($urandom_range(0, 2) == 0);
      bus.player_shot_valid = ($urandom_range(0, 5) == 0);
      bus.player_hit        = ($urandom_range(0, 1) == 0);
      bus.pc_shot_valid     = ($urandom_range(0, 5) == 0);
      bus.pc_hit            = ($urandom_range(0, 1) == 0);
      tick();
      n_checks++;
      if (tp_seen !== m_tp) begin
        n_errors++; $display("[TB] FAIL random_timeout: cycle %0d got %b expected %b", i, tp_seen, m_tp);
      end
      n_checks++;
      if (dut_snap !== exp_snap()) begin
        n_errors++; $display("[TB] FAIL random_outputs: cycle %0d got %h expected %h", i, dut_snap, exp_snap());
      end
    end
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.start_btn = 1'b0; bus.ships_cfg = 3'd0; bus.place_done = 1'b0;
    bus.player_shot_valid = 1'b0; bus.player_hit = 1'b0;
    bus.pc_shot_valid = 1'b0; bus.pc_hit = 1'b0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_setup();
    test_win();
    test_alternation();
    test_timeout();
    test_illegal_abort();
    test_midgame_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
